// File: rtl/collision_event_gen_pkg.sv
// Shared types and constants for the collision event generator: FSM state
// encoding, default pulse timing, floor line and hit-counter sizing.
package collision_event_gen_pkg;

    typedef enum logic [2:0] {
        SCAN     = 3'd0,
        SCORE_HI = 3'd1,
        SCORE_LO = 3'd2,
        LIFE_HI  = 3'd3,
        LIFE_LO  = 3'd4
    } state_e;

    localparam int          PULSE_HI_DEFAULT = 2;
    localparam int          PULSE_LO_DEFAULT = 2;
    localparam logic [8:0]  FLOOR_Y_DEFAULT  = 9'd232;

    localparam int          TIMER_W = 4;

    localparam int                   HIT_CNT_W   = 3;
    localparam logic [HIT_CNT_W-1:0] HIT_CNT_MAX = 3'd7;

endpackage

// File: rtl/collision_event_gen_pulse_timer.sv
// Countdown timer for pulse high/low phases. A load sets the phase length;
// done_o is high on the final clock of the loaded phase.
module pulse_timer
    import collision_event_gen_pkg::*;
#(
    parameter int PULSE_HI = PULSE_HI_DEFAULT,
    parameter int PULSE_LO = PULSE_LO_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic loadHi_i,
    input  logic loadLo_i,
    output logic done_o
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    // Loading length-1 makes the phase last exactly its length, counting the load clock's successor.
    always_comb begin
        cnt_d = cnt_q;
        if (loadHi_i) begin
            cnt_d = TIMER_W'(PULSE_HI - 1);
        end else if (loadLo_i) begin
            cnt_d = TIMER_W'(PULSE_LO - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/collision_event_gen.sv
// Turns per-pixel ball/brick/paddle/floor overlaps into per-frame score and
// life-loss pulses. Define COLLISION_COMBO_SCORE_EN for one score pulse per brick hit.
module collision_event_gen
    import collision_event_gen_pkg::*;
#(
    parameter int         PULSE_HI = PULSE_HI_DEFAULT,
    parameter int         PULSE_LO = PULSE_LO_DEFAULT,
    parameter logic [8:0] FLOOR_Y  = FLOOR_Y_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       display_on,
    input  logic       vsync,
    input  logic [8:0] hpos,
    input  logic [8:0] vpos,
    input  logic       ball_gfx,
    input  logic       brick_gfx,
    input  logic       paddle_gfx,
    output logic       incscore,
    output logic       declives,
    output logic       paddle_hit,
    output logic       busy
);

`ifdef COLLISION_COMBO_SCORE_EN
    localparam int               CNT_W   = HIT_CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = HIT_CNT_MAX;
`else
    localparam int               CNT_W   = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = 1'b1;
`endif

    state_e state_q, state_d;

    logic             vsyncPrev_q;
    logic             brickOvl_q;
    logic [CNT_W-1:0] liveCnt_q, liveCnt_d;
    logic             liveFloor_q, liveFloor_d;
    logic             livePaddle_q, livePaddle_d;
    logic [CNT_W-1:0] pendCnt_q, pendCnt_d;
    logic             life_q, life_d;
    logic             paddleHit_q, paddleHit_d;
    logic             incscore_q, declives_q, busy_q;

    logic vsyncRise, snap;
    logic brickOvl, brickEdge, floorHit, paddleOvl;
    logic loadHi, loadLo, timerDone;
    logic unusedHpos;

    assign unusedHpos = ^hpos;

    assign vsyncRise = vsync & ~vsyncPrev_q;
    assign snap      = vsyncRise && (state_q == SCAN);

    assign brickOvl  = display_on & ball_gfx & brick_gfx;
    assign brickEdge = brickOvl & ~brickOvl_q;
    assign floorHit  = display_on & ball_gfx & (vpos >= FLOOR_Y);
    assign paddleOvl = display_on & ball_gfx & paddle_gfx;

    // Snapshot clears first, so overlaps seen in the snapshot clock land in the new frame.
    always_comb begin
        liveCnt_d    = snap ? '0   : liveCnt_q;
        liveFloor_d  = snap ? 1'b0 : liveFloor_q;
        livePaddle_d = snap ? 1'b0 : livePaddle_q;
        if (brickEdge && (liveCnt_d != CNT_MAX)) begin
            liveCnt_d = liveCnt_d + CNT_W'(1);
        end
        liveFloor_d  = liveFloor_d | floorHit;
        livePaddle_d = livePaddle_d | paddleOvl;
    end

    always_comb begin
        state_d     = state_q;
        pendCnt_d   = pendCnt_q;
        life_d      = life_q;
        paddleHit_d = paddleHit_q;
        loadHi      = 1'b0;
        loadLo      = 1'b0;
        case (state_q)
            SCAN: begin
                if (snap) begin
                    pendCnt_d   = liveCnt_q;
                    life_d      = liveFloor_q;
                    paddleHit_d = livePaddle_q;
                    if (liveCnt_q != '0) begin
                        state_d = SCORE_HI;
                        loadHi  = 1'b1;
                    end else if (liveFloor_q) begin
                        state_d = LIFE_HI;
                        loadHi  = 1'b1;
                    end
                end
            end
            SCORE_HI: begin
                if (timerDone) begin
                    state_d   = SCORE_LO;
                    loadLo    = 1'b1;
                    pendCnt_d = pendCnt_q - CNT_W'(1);
                end
            end
            SCORE_LO: begin
                if (timerDone) begin
                    if (pendCnt_q != '0) begin
                        state_d = SCORE_HI;
                        loadHi  = 1'b1;
                    end else if (life_q) begin
                        state_d = LIFE_HI;
                        loadHi  = 1'b1;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            LIFE_HI: begin
                if (timerDone) begin
                    state_d = LIFE_LO;
                    loadLo  = 1'b1;
                    life_d  = 1'b0;
                end
            end
            LIFE_LO: begin
                if (timerDone) begin
                    state_d = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // Outputs are flopped from the next state so they line up with state_q and cannot glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= SCAN;
            vsyncPrev_q  <= 1'b0;
            brickOvl_q   <= 1'b0;
            liveCnt_q    <= '0;
            liveFloor_q  <= 1'b0;
            livePaddle_q <= 1'b0;
            pendCnt_q    <= '0;
            life_q       <= 1'b0;
            paddleHit_q  <= 1'b0;
            incscore_q   <= 1'b0;
            declives_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsyncPrev_q  <= vsync;
            brickOvl_q   <= brickOvl;
            liveCnt_q    <= liveCnt_d;
            liveFloor_q  <= liveFloor_d;
            livePaddle_q <= livePaddle_d;
            pendCnt_q    <= pendCnt_d;
            life_q       <= life_d;
            paddleHit_q  <= paddleHit_d;
            incscore_q   <= (state_d == SCORE_HI);
            declives_q   <= (state_d == LIFE_HI);
            busy_q       <= (state_d != SCAN);
        end
    end

    pulse_timer #(
        .PULSE_HI (PULSE_HI),
        .PULSE_LO (PULSE_LO)
    ) u_pulse_timer (
        .clk      (clk),
        .reset    (reset),
        .loadHi_i (loadHi),
        .loadLo_i (loadLo),
        .done_o   (timerDone)
    );

    assign incscore   = incscore_q;
    assign declives   = declives_q;
    assign paddle_hit = paddleHit_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_collision_event_gen.sv
// Directed self-checking bench for collision_event_gen; expected pulse counts
// follow COLLISION_COMBO_SCORE_EN when it is defined for the build.
module tb_collision_event_gen;

    logic       clk;
    logic       reset;
    logic       display_on;
    logic       vsync;
    logic [8:0] hpos;
    logic [8:0] vpos;
    logic       ball_gfx;
    logic       brick_gfx;
    logic       paddle_gfx;
    logic       incscore;
    logic       declives;
    logic       paddle_hit;
    logic       busy;

    int testsRun    = 0;
    int testsFailed = 0;

`ifdef COLLISION_COMBO_SCORE_EN
    localparam bit COMBO = 1'b1;
`else
    localparam bit COMBO = 1'b0;
`endif

    collision_event_gen dut (
        .clk        (clk),
        .reset      (reset),
        .display_on (display_on),
        .vsync      (vsync),
        .hpos       (hpos),
        .vpos       (vpos),
        .ball_gfx   (ball_gfx),
        .brick_gfx  (brick_gfx),
        .paddle_gfx (paddle_gfx),
        .incscore   (incscore),
        .declives   (declives),
        .paddle_hit (paddle_hit),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        hpos = hpos + 9'd1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int hits);
        for (int i = 0; i < hits; i++) begin
            display_on = 1'b1;
            ball_gfx   = 1'b1;
            brick_gfx  = 1'b1;
            step();
            ball_gfx   = 1'b0;
            brick_gfx  = 1'b0;
            step();
        end
    endtask

    task automatic floorTouch();
        display_on = 1'b1;
        vpos       = 9'd240;
        ball_gfx   = 1'b1;
        step();
        ball_gfx   = 1'b0;
        vpos       = 9'd100;
        step();
    endtask

    task automatic frameEnd();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
    endtask

    task automatic watchReport(input int cycles,
                               output int incPulses, output int incHigh,
                               output int decPulses, output int decHigh,
                               output int busyCycles, output int bothHigh,
                               output int lastIncIdx, output int firstDecIdx);
        logic prevInc, prevDec;
        incPulses = 0; incHigh = 0; decPulses = 0; decHigh = 0;
        busyCycles = 0; bothHigh = 0; lastIncIdx = -1; firstDecIdx = -1;
        prevInc = 1'b0; prevDec = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (incscore === 1'b1) begin
                incHigh++;
                lastIncIdx = i;
                if (!prevInc) incPulses++;
            end
            if (declives === 1'b1) begin
                decHigh++;
                if (firstDecIdx < 0) firstDecIdx = i;
                if (!prevDec) decPulses++;
            end
            if (busy === 1'b1) busyCycles++;
            if (incscore === 1'b1 && declives === 1'b1) bothHigh++;
            prevInc = incscore;
            prevDec = declives;
            step();
        end
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        checkOutput(tag, int'(busy), 0);
    endtask

    initial begin
        int incP, incH, decP, decH, busyC, both, lastInc, firstDec;
        int expInc;

        reset = 1'b1; display_on = 1'b0; vsync = 1'b0;
        hpos = '0; vpos = 9'd100;
        ball_gfx = 1'b0; brick_gfx = 1'b0; paddle_gfx = 1'b0;
        step(); step();
        checkOutput("reset_incscore", int'(incscore), 0);
        checkOutput("reset_declives", int'(declives), 0);
        checkOutput("reset_paddle_hit", int'(paddle_hit), 0);
        checkOutput("reset_busy", int'(busy), 0);
        reset = 1'b0;
        step();

        // Three separate brick hits in one frame.
        applyStimulus(3);
        frameEnd();
        checkOutput("three_first_high", int'(incscore), 1);
        watchReport(40, incP, incH, decP, decH, busyC, both, lastInc, firstDec);
        expInc = COMBO ? 3 : 1;
        checkOutput("three_inc_pulses", incP, expInc);
        checkOutput("three_inc_high", incH, 2 * expInc);
        checkOutput("three_busy", busyC, 4 * expInc);
        checkOutput("three_dec_pulses", decP, 0);

        // Ten hits saturate the combo counter at seven.
        applyStimulus(10);
        frameEnd();
        watchReport(40, incP, incH, decP, decH, busyC, both, lastInc, firstDec);
        expInc = COMBO ? 7 : 1;
        checkOutput("ten_inc_pulses", incP, expInc);
        checkOutput("ten_inc_high", incH, 2 * expInc);
        checkOutput("ten_busy", busyC, 4 * expInc);

        // Floor touch plus one brick: score first, then one life loss.
        applyStimulus(1);
        floorTouch();
        frameEnd();
        watchReport(40, incP, incH, decP, decH, busyC, both, lastInc, firstDec);
        checkOutput("floor_inc_pulses", incP, 1);
        checkOutput("floor_dec_pulses", decP, 1);
        checkOutput("floor_dec_high", decH, 2);
        checkOutput("floor_both_high", both, 0);
        checkOutput("floor_order", int'(lastInc < firstDec), 1);
        checkOutput("floor_busy", busyC, 8);

        // Overlaps outside the visible area are ignored.
        display_on = 1'b0; vpos = 9'd240;
        ball_gfx = 1'b1; brick_gfx = 1'b1; paddle_gfx = 1'b1;
        step(); step(); step();
        ball_gfx = 1'b0; brick_gfx = 1'b0; paddle_gfx = 1'b0; vpos = 9'd100;
        step();
        frameEnd();
        watchReport(20, incP, incH, decP, decH, busyC, both, lastInc, firstDec);
        checkOutput("blank_inc_pulses", incP, 0);
        checkOutput("blank_dec_pulses", decP, 0);
        checkOutput("blank_busy", busyC, 0);
        checkOutput("blank_paddle_hit", int'(paddle_hit), 0);

        // Paddle contact is reported for one frame only.
        display_on = 1'b1; ball_gfx = 1'b1; paddle_gfx = 1'b1;
        step();
        ball_gfx = 1'b0; paddle_gfx = 1'b0;
        step();
        checkOutput("paddle_before_vsync", int'(paddle_hit), 0);
        frameEnd();
        checkOutput("paddle_after_vsync", int'(paddle_hit), 1);
        checkOutput("paddle_no_busy", int'(busy), 0);
        step(); step();
        frameEnd();
        checkOutput("paddle_next_frame", int'(paddle_hit), 0);

        // Asynchronous reset in the middle of a score pulse.
        applyStimulus(3);
        frameEnd();
        if (COMBO) begin
            step(); step(); step(); step();
        end else begin
            step();
        end
        checkOutput("midpulse_inc_high", int'(incscore), 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midpulse_inc_cleared", int'(incscore), 0);
        checkOutput("midpulse_busy_cleared", int'(busy), 0);
        step(); step();
        reset = 1'b0;
        step();
        applyStimulus(1);
        frameEnd();
        watchReport(30, incP, incH, decP, decH, busyC, both, lastInc, firstDec);
        checkOutput("postreset_inc_pulses", incP, 1);
        checkOutput("postreset_busy", busyC, 4);

        // Hits and a vsync rise arriving while a report is still running.
        applyStimulus(1);
        floorTouch();
        frameEnd();
        applyStimulus(2);
        checkOutput("pending_busy_at_vsync", int'(busy), 1);
        frameEnd();
        waitIdle("pending_idle_timeout");
        frameEnd();
        watchReport(30, incP, incH, decP, decH, busyC, both, lastInc, firstDec);
        expInc = COMBO ? 2 : 1;
        checkOutput("pending_inc_pulses", incP, expInc);
        checkOutput("pending_dec_pulses", decP, 0);
        checkOutput("pending_busy", busyC, 4 * expInc);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/collision_event_gen.md
COLLISION_EVENT_GEN -- requirements
Module: collision_event_gen

Interface
REQ-001 Parameter PULSE_HI, default 2, meaning clocks each output pulse is held high (range 1..15).
REQ-002 Parameter PULSE_LO, default 2, meaning minimum low clocks between consecutive pulses (range 1..15).
REQ-003 Parameter FLOOR_Y, default 9'd232, meaning first scanline counted as floor.
REQ-004 Port clk  input  1  pixel clock.
REQ-005 Port reset  input  1  reset, asynchronous, active-high.
REQ-006 Port display_on  input  1  visible-area qualifier from the sync generator.
REQ-007 Port vsync  input  1  vertical sync; its rising edge marks end of frame.
REQ-008 Port hpos, vpos  input  9 each  current beam position.
REQ-009 Port ball_gfx, brick_gfx, paddle_gfx  input  1 each  per-pixel object coverage.
REQ-010 Port incscore  output  1  registered score pulse, feeds the player statistics incscore input.
REQ-011 Port declives  output  1  registered life-loss pulse, feeds the player statistics declives input.
REQ-012 Port paddle_hit  output  1  high for the whole frame following a frame with any ball/paddle overlap.
REQ-013 Port busy  output  1  high while a report sequence is in progress.

Function
REQ-014 Overlaps SHALL be sampled only when display_on=1.
REQ-015 Live brick counter (3-bit) SHALL increment on each 0->1 transition of (ball_gfx & brick_gfx), saturating at 7.
REQ-016 Live floor flag SHALL set when ball_gfx=1 and vpos >= FLOOR_Y; live paddle flag SHALL set on ball_gfx & paddle_gfx.
REQ-017 vsync rising edge SHALL be detected with a registered previous-vsync bit (1 clock latency).
REQ-018 On vsync rise with FSM in SCAN: snapshot live counter and flags, clear live state in the same clock, enter REPORT.
REQ-019 On vsync rise with FSM not in SCAN: no snapshot; live state keeps accumulating (saturating) until the next vsync rise found in SCAN.
REQ-020 FSM states: SCAN, SCORE_HI, SCORE_LO, LIFE_HI, LIFE_LO; busy=1 in all but SCAN.
REQ-021 REPORT order: all incscore pulses first, then at most one declives pulse, then return to SCAN.
REQ-022 Each pulse SHALL be high exactly PULSE_HI clocks and followed by exactly PULSE_LO low clocks.
REQ-023 Snapshot brick count 0 and floor flag 0 SHALL return to SCAN in one clock without pulses.
REQ-024 incscore and declives SHALL never be high in the same clock and SHALL be glitch-free register outputs.
REQ-025 paddle_hit SHALL update from the snapshot in the snapshot clock and hold until the next snapshot.
REQ-026 Overlap first pixel at the same clock as vsync rise SHALL count toward the live (next) frame.

Reset
REQ-027 Reset SHALL force SCAN, incscore=0, declives=0, paddle_hit=0, busy=0, clear live/snapshot state and vsync history, immediately and asynchronously, including mid-pulse.
REQ-028 First vsync rise after reset release SHALL be treated as a normal frame end.

Configuration
REQ-029 Macro COLLISION_COMBO_SCORE_EN defined: one incscore pulse per counted brick hit (1..7).
REQ-030 Macro COLLISION_COMBO_SCORE_EN undefined: at most one incscore pulse per reported frame when count >= 1; counter may be reduced to a 1-bit flag.

Structure
REQ-031 Shared package SHALL hold FSM state encoding, default PULSE_HI/PULSE_LO/FLOOR_Y and the hit-count width/saturation constant.
REQ-032 Sub-module pulse_timer SHALL implement the PULSE_HI/PULSE_LO countdown with load/done handshake; FSM instantiates one.

Verification
REQ-033 Three separate ball/brick overlaps in one frame, combo on -> after vsync rise exactly 3 incscore pulses, each 2 high/2 low, busy high 12 clocks then low.
REQ-034 Ten overlaps, combo on -> 7 incscore pulses; combo off -> 1 pulse.
REQ-035 Ball at vpos=240 plus one brick hit -> 1 incscore then 1 declives, never overlapping.
REQ-036 Overlaps with display_on=0 only -> no pulses, paddle_hit stays 0.
REQ-037 Reset asserted during second incscore high -> incscore low same clock, busy=0, next clean frame reports only its own hits.
REQ-038 vsync rise while busy with 2 new hits pending -> those 2 reported after next vsync rise in SCAN.
